fifo_rd_stream: RTL
===================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The block SHALL have parameter DSIZE, default 8, giving the data width in bits.
REQ-002 The block SHALL have parameter CSIZE, default 16, giving the width of the statistics counter.
REQ-003 The block SHALL have input port rclk, 1 bit, the single clock; all state SHALL be updated on its rising edge.
REQ-004 The block SHALL have input port rrst_n, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have input port enable, 1 bit; a high level requests streaming.
REQ-006 The block SHALL have input port rdata, DSIZE bits, the FIFO head word, valid whenever rempty=0.
REQ-007 The block SHALL have input port rempty, 1 bit, the FIFO empty flag.
REQ-008 The block SHALL have output port rinc, 1 bit, the FIFO pop strobe; one word is popped per cycle it is high.
REQ-009 The block SHALL have output port m_data, DSIZE bits, the downstream data, driven from a register.
REQ-010 The block SHALL have output port m_valid, 1 bit, the downstream valid.
REQ-011 The block SHALL have input port m_ready, 1 bit, the downstream ready.
REQ-012 The block SHALL have output port busy, 1 bit, high whenever the state is not IDLE.
REQ-013 The block SHALL have output port word_cnt, CSIZE bits, present only when FIFO_RD_STREAM_STATS_EN is defined.

Function
REQ-014 The block SHALL contain a 2-entry output buffer with occupancy cnt (0..2), in-order, with the head word driven on m_data.
REQ-015 The state machine SHALL have three states: IDLE, STREAM and FLUSH.
REQ-016 The state SHALL move from IDLE to STREAM when enable=1.
REQ-017 The state SHALL move from STREAM to FLUSH when enable=0.
REQ-018 The state SHALL move from FLUSH to IDLE when cnt=0 and no pop is in progress.
REQ-019 The state SHALL move from FLUSH to STREAM when enable=1.
REQ-020 rinc SHALL be combinational: rinc = (state==STREAM) && !rempty && (cnt<2).
REQ-021 A pop SHALL capture rdata into the buffer tail at the same rclk edge.
REQ-022 m_valid SHALL be high in the cycle after the pop.
REQ-023 m_valid SHALL equal (cnt!=0).
REQ-024 A transfer SHALL occur when m_valid && m_ready, and it SHALL remove the head word.
REQ-025 A simultaneous pop and transfer SHALL leave cnt unchanged and SHALL keep word order.
REQ-026 When cnt=2, rinc SHALL be 0 even if m_ready=1; no word SHALL be lost or duplicated.
REQ-027 m_data and m_valid SHALL hold stable while m_valid=1 and m_ready=0.
REQ-028 When rempty=1, rinc SHALL be 0 (no underflow pop) and buffered words SHALL still drain.
REQ-029 Steady state with rempty=0 and m_ready=1 SHALL sustain one word per cycle.
REQ-030 FLUSH SHALL never assert rinc.
REQ-031 In FLUSH, buffered words SHALL drain to downstream normally.
REQ-032 busy SHALL equal (state!=IDLE).

Reset
REQ-033 Asserting rrst_n=0 SHALL immediately force state=IDLE, cnt=0, m_valid=0, m_data=0 and rinc=0, including mid-transfer.
REQ-034 Asserting rrst_n=0 SHALL immediately force busy=0 and word_cnt=0.
REQ-035 Buffered words SHALL be discarded on reset.
REQ-036 The first pop after release SHALL occur no earlier than the second rclk edge after rrst_n rises.

Configuration
REQ-037 With macro FIFO_RD_STREAM_STATS_EN defined, word_cnt SHALL increment by 1 on each downstream transfer.
REQ-038 word_cnt SHALL wrap from 2^CSIZE-1 to 0.
REQ-039 word_cnt SHALL not saturate.
REQ-040 Without FIFO_RD_STREAM_STATS_EN, the word_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-041 Reset mid-stream: set cnt=2, then pulse rrst_n low -> m_valid=0, rinc=0, busy=0 the same cycle; word_cnt=0.
REQ-042 Streaming: FIFO preloaded with 0x11,0x22,0x33, enable=1, m_ready=1 -> rinc high 3 consecutive cycles; m_data 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after the first rinc; word_cnt=3.
REQ-043 Backpressure: 4 words queued, m_ready=0 -> exactly 2 pops then rinc=0 and m_data held at the first word; m_ready=1 -> all 4 words in order, no duplicates.
REQ-044 Empty: rempty=1, enable=1 for 10 cycles -> rinc never asserted, m_valid=0, busy=1.
REQ-045 Flush: enable dropped with cnt=2 and m_ready=1 -> no further rinc; 2 words delivered; busy falls the cycle after cnt reaches 0.
REQ-046 Counter wrap: CSIZE=4, 17 transfers -> word_cnt=1.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Drains the read side of a FIFO into a valid/ready stream through a 2-entry
// in-order skid buffer. An IDLE/STREAM/FLUSH controller pops the FIFO while
// streaming is enabled. Once enable drops, it stops popping and lets the
// buffered words drain.
//
// Optional feature: define FIFO_RD_STREAM_STATS_EN to add the word_cnt port,
// a wrapping count of downstream transfers.
//
// Ports
//   rclk      in   clock, all state on rising edge
//   rrst_n    in   asynchronous active-low reset
//   enable    in   request streaming
//   rdata     in   FIFO head word (valid when rempty=0)
//   rempty    in   FIFO empty flag
//   rinc      out  FIFO pop strobe (combinational)
//   m_data    out  downstream data (registered buffer head)
//   m_valid   out  downstream valid (registered)
//   m_ready   in   downstream ready
//   busy      out  controller not IDLE (registered)
//   word_cnt  out  transfer count, only with FIFO_RD_STREAM_STATS_EN
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
   parameter int unsigned DSIZE = 8,
   parameter int unsigned CSIZE = 16
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic             enable,
   input  logic [DSIZE-1:0] rdata,
   input  logic             rempty,
   output logic             rinc,
   output logic [DSIZE-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             busy
`ifdef FIFO_RD_STREAM_STATS_EN
   ,
   output logic [CSIZE-1:0] word_cnt
`endif
);

   localparam int unsigned CNT_W = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DSIZE-1:0]   buf0_q, buf0_d;
   logic [DSIZE-1:0]   buf1_q, buf1_d;
   logic               valid_q;
   logic               busy_q;
   logic               pop;
   logic               xfer;

   // Pop only while streaming, with data available and buffer room.
   assign rinc = (state_q == STREAM) && !rempty && (cnt_q < CNT_W'(2));
   assign pop  = rinc;
   assign xfer = valid_q && m_ready;

   assign m_data  = buf0_q;
   assign m_valid = valid_q;
   assign busy    = busy_q;

   // Controller next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable) state_d = STREAM;
         STREAM:  if (!enable) state_d = FLUSH;
         FLUSH: begin
            if (enable)
               state_d = STREAM;
            else if ((cnt_q == CNT_W'(0)) && !pop)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Buffer next state; buf0 is always the head.
   always_comb begin
      buf0_d = buf0_q;
      buf1_d = buf1_q;
      cnt_d  = cnt_q;
      case ({pop, xfer})
         2'b10: begin
            if (cnt_q == CNT_W'(0))
               buf0_d = rdata;
            else
               buf1_d = rdata;
            cnt_d = cnt_q + CNT_W'(1);
         end
         2'b01: begin
            buf0_d = buf1_q;
            cnt_d  = cnt_q - CNT_W'(1);
         end
         // Pop implies cnt<2 and transfer implies cnt>=1, so cnt==1 here:
         // the head leaves and the new word becomes the head.
         2'b11:   buf0_d = rdata;
         default: ;
      endcase
   end

   // State and buffer registers.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         buf0_q  <= '0;
         buf1_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf0_q  <= buf0_d;
         buf1_q  <= buf1_d;
         valid_q <= (cnt_d != CNT_W'(0));
         busy_q  <= (state_d != IDLE);
      end
   end

`ifdef FIFO_RD_STREAM_STATS_EN
   logic [CSIZE-1:0] word_cnt_q;

   // Free-running transfer counter, wraps at 2^CSIZE.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n)
         word_cnt_q <= '0;
      else if (xfer)
         word_cnt_q <= word_cnt_q + CSIZE'(1);
   end

   assign word_cnt = word_cnt_q;
`else
   // No statistics counter in this build.
`endif

endmodule
